// File: rtl/fifo_sameclock_burst_writer.sv
// Write-side controller for a same-clock BRAM FIFO. It reserves FIFO space for a whole
// burst before accepting any upstream data, so the FIFO can never overflow.
//
//  state  | meaning
//  IDLE   | no burst; burst_req/burst_len sampled here
//  WAIT   | burst length latched; waiting until free space covers it
//  XFER   | streaming accepted words into the FIFO
module fifo_sameclock_burst_writer #(
  parameter int WIDTH      = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH:0]        fill_in,
  input  logic                  burst_req,
  input  logic [WIDTH:0]        burst_len,
  output logic                  burst_grant,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  din_ready,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  err_len
);

  localparam logic [WIDTH:0] DEPTH = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH:0]        remain_q, remain_d;
  logic                  ok_q, ok_d;
  logic                  din_ready_q, din_ready_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  burst_done_q, burst_done_d;
  logic                  err_len_q, err_len_d;

  logic [WIDTH:0] free;
  logic           len_legal;
  logic           accept;

  // A write issued this cycle is not yet reflected in fill_in, so charge it here.
  assign free      = DEPTH - fill_in - {{WIDTH{1'b0}}, wr_q};
  assign len_legal = (burst_len != '0) && (burst_len <= DEPTH);
  assign accept    = din_valid && din_ready_q;

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    ok_d         = 1'b0;
    din_ready_d  = din_ready_q;
    wr_d         = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    burst_done_d = 1'b0;
    err_len_d    = 1'b0;
    burst_grant  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (burst_req) begin
          if (len_legal) begin
            remain_d = burst_len;
            state_d  = S_WAIT;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // ok_q is one cycle old; reads only grow free space, so granting on it is safe.
        if (ok_q) begin
          burst_grant = 1'b1;
          din_ready_d = 1'b1;
          state_d     = S_XFER;
        end else begin
          ok_d = (free >= remain_q);
        end
      end
      S_XFER: begin
        if (accept) begin
          wr_d        = 1'b1;
          mem_wdata_d = din;
          remain_d    = remain_q - ONE;
          if (remain_q == ONE) begin
            din_ready_d  = 1'b0;
            burst_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        din_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      remain_q     <= '0;
      ok_q         <= 1'b0;
      din_ready_q  <= 1'b0;
      wr_q         <= 1'b0;
      mem_wdata_q  <= '0;
      burst_done_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      ok_q         <= ok_d;
      din_ready_q  <= din_ready_d;
      wr_q         <= wr_d;
      mem_wdata_q  <= mem_wdata_d;
      burst_done_q <= burst_done_d;
      err_len_q    <= err_len_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign wr         = wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign burst_done = burst_done_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_fifo_sameclock_burst_writer.sv
// Bench for fifo_sameclock_burst_writer: directed bursts against a FIFO fill model,
// with a scoreboard monitor checking every write word and its burst_done flag.
module tb_fifo_sameclock_burst_writer;

  localparam int WIDTH = 9;
  localparam int DW    = 64;
  localparam int DEPTH = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH:0]   fill_in;
  logic             burst_req;
  logic [WIDTH:0]   burst_len;
  logic             burst_grant;
  logic             din_valid;
  logic [DW-1:0]    din;
  logic             din_ready;
  logic             wr;
  logic [DW-1:0]    mem_wdata;
  logic             busy;
  logic             burst_done;
  logic             err_len;

  int   fill = 0;
  int   fill_val = 0;
  int   max_fill = 0;
  logic fill_load = 1'b0;
  logic rd = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_sameclock_burst_writer #(.WIDTH(WIDTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_in    (fill_in),
    .burst_req  (burst_req),
    .burst_len  (burst_len),
    .burst_grant(burst_grant),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .wr         (wr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .burst_done (burst_done),
    .err_len    (err_len)
  );

  // FIFO fill model: fill_in includes the write of the previous cycle.
  assign fill_in = fill[WIDTH:0];
  always @(posedge clk) begin
    if (fill_load) fill <= fill_val;
    else           fill <= fill + int'(wr) - int'(rd);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event-missing expected event", name);
  endtask

  // Scoreboard monitor
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (fill > max_fill) max_fill = fill;
      if (wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wr_unexpected: got wr=1 data=%0h expected no write", mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wdata_done", {burst_done, mem_wdata}, e);
        end
      end else if (burst_done === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL done_without_wr: got burst_done=1 expected 0");
      end
    end
  end

  task automatic push_exp(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), base + 64'(i)});
  endtask

  task automatic set_fill(input int v);
    fill_val  = v;
    fill_load = 1'b1;
    @(negedge clk);
    fill_load = 1'b0;
  endtask

  task automatic request(input int len, output int lat, output int fill_g);
    burst_req = 1'b1;
    burst_len = 10'(len);
    lat = 0;
    fill_g = -1;
    do begin
      @(negedge clk);
      burst_req = 1'b0;
      lat++;
    end while (!burst_grant && lat < 2000);
    if (burst_grant) fill_g = fill;
    else fail_now("grant_timeout");
  endtask

  task automatic send(input int n, input logic [DW-1:0] base, input int pat, output int cyc);
    int   idx;
    logic acc;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 5000) begin
      din       = base + 64'(idx);
      din_valid = (pat == 0) || (cyc % 3 == 0);
      acc       = din_valid && din_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    din_valid = 1'b0;
    if (idx < n) fail_now("send_timeout");
  endtask

  initial begin
    int lat, fg, cyc;
    logic g;
    rst = 1'b1;
    burst_req = 1'b0;
    burst_len = '0;
    din_valid = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {wr, burst_grant, burst_done, err_len, busy, din_ready}, 6'b0);
    check("rst_wdata", mem_wdata, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: empty FIFO, len 16, continuous valid
    push_exp(16, 64'h1000);
    request(16, lat, fg);
    check("t1_grant_lat", lat, 2);
    send(16, 64'h1000, 0, cyc);
    check("t1_consecutive", cyc, 17);
    @(negedge clk);
    check("t1_din_ready_low", din_ready, 0);
    check("t1_busy_low", busy, 0);
    check("t1_fill", fill, 16);

    // 2: nearly full FIFO, grant only after reader drains enough
    set_fill(500);
    push_exp(20, 64'h2000);
    burst_req = 1'b1;
    burst_len = 10'd20;
    @(negedge clk);
    burst_req = 1'b0;
    g = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (burst_grant) g = 1'b1;
      @(negedge clk);
    end
    check("t2_busy_waiting", busy, 1);
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (burst_grant) g = 1'b1;
      @(negedge clk);
    end
    rd = 1'b0;
    check("t2_no_early_grant", g, 0);
    lat = 0;
    while (!burst_grant && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!burst_grant) fail_now("t2_grant_timeout");
    check("t2_fill_at_grant", fill, 492);
    send(20, 64'h2000, 0, cyc);
    @(negedge clk);
    check("t2_fill_full", fill, 512);

    // 3: illegal lengths
    burst_req = 1'b1;
    burst_len = 10'd0;
    @(negedge clk);
    burst_req = 1'b0;
    check("t3_err_len0", {err_len, busy}, 2'b10);
    @(negedge clk);
    check("t3_err_pulse0", {err_len, busy}, 2'b00);
    burst_req = 1'b1;
    burst_len = 10'd513;
    @(negedge clk);
    burst_req = 1'b0;
    check("t3_err_len513", {err_len, busy}, 2'b10);
    @(negedge clk);
    check("t3_err_pulse513", {err_len, busy}, 2'b00);

    // 4: bubbly valid pattern 1,0,0
    set_fill(0);
    push_exp(8, 64'h4000);
    request(8, lat, fg);
    check("t4_grant_lat", lat, 2);
    send(8, 64'h4000, 1, cyc);
    check("t4_cycles", cyc, 25);

    // 5: back-to-back 256 + 256, then len 1 must wait
    set_fill(0);
    push_exp(256, 64'h5000);
    request(256, lat, fg);
    check("t5a_grant_lat", lat, 2);
    send(256, 64'h5000, 0, cyc);
    check("t5_done_b2b", burst_done, 1);
    push_exp(256, 64'h6000);
    request(256, lat, fg);
    check("t5b_grant_lat", lat, 2);
    check("t5b_fill_at_grant", fg, 256);
    send(256, 64'h6000, 0, cyc);
    burst_req = 1'b1;
    burst_len = 10'd1;
    @(negedge clk);
    burst_req = 1'b0;
    g = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (burst_grant) g = 1'b1;
      @(negedge clk);
    end
    check("t5_len1_no_grant", g, 0);
    check("t5_len1_busy", busy, 1);
    check("t5_fill_full", fill, 512);

    // 6: reset mid-burst, then a normal burst
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_fill(0);
    push_exp(10, 64'h7000);
    request(10, lat, fg);
    send(5, 64'h7000, 0, cyc);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outputs", {wr, burst_grant, burst_done, err_len, busy, din_ready}, 6'b0);
    check("t6_rst_wdata", mem_wdata, 64'h0);
    check("t6_words_written", 10 - exp_q.size(), 5);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    push_exp(4, 64'h8000);
    request(4, lat, fg);
    check("t6_grant_lat", lat, 2);
    send(4, 64'h8000, 0, cyc);
    @(negedge clk);
    check("t6_busy_low", busy, 0);
    check("t6_fill", fill, 9);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("never_over", (max_fill > DEPTH), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
